// File: rtl/hazard_pkg.sv
// hazard_pkg: shared widths, forwarding codes, stage entry type and forwarding priority helper
package hazard_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS = 32;
    localparam logic [1:0] FWD_REGFILE = 2'd0;
    localparam logic [1:0] FWD_EXDM = 2'd1;
    localparam logic [1:0] FWD_DMWB = 2'd2;
    typedef struct packed {
        logic v;
        logic [REG_ADDR_W-1:0] rd;
        logic ld;
    } stage_t;
    // youngest producer wins: EX_DM result beats DM_WB result
    function automatic logic [1:0] fwd_sel(stage_t ex, stage_t dm, logic [REG_ADDR_W-1:0] src);
        return (ex.v && ex.rd == src) ? FWD_EXDM : (dm.v && dm.rd == src) ? FWD_DMWB : FWD_REGFILE;
    endfunction
endpackage

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: ID/EX hazard inputs and pipeline control outputs of the scoreboard
interface hazard_scoreboard_if;
    import hazard_pkg::*;
    logic id_valid;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic id_uses_rt;
    logic [REG_ADDR_W-1:0] id_rd;
    logic id_reg_write;
    logic id_mem_read;
    logic ex_branch_taken;
    logic stall;
    logic id_ex_bubble;
    logic if_id_flush;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic [NUM_REGS-1:0] busy;
    modport master (
        output id_valid, id_rs, id_rt, id_uses_rt, id_rd, id_reg_write, id_mem_read, ex_branch_taken,
        input stall, id_ex_bubble, if_id_flush, fwd_a, fwd_b, busy
    );
    modport slave (
        input id_valid, id_rs, id_rt, id_uses_rt, id_rd, id_reg_write, id_mem_read, ex_branch_taken,
        output stall, id_ex_bubble, if_id_flush, fwd_a, fwd_b, busy
    );
endinterface

// File: rtl/reg_pending_counter.sv
// reg_pending_counter: count of in-flight writes to one register, busy while nonzero
module reg_pending_counter #(
    parameter int CNT_W = 2
) (
    input logic clk,
    input logic reset,
    input logic inc,
    input logic dec,
    output logic busy
);
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt <= '0;
        else cnt <= (inc && !dec) ? cnt + 1'b1 : (dec && !inc) ? cnt - 1'b1 : cnt;
    end
    assign busy = cnt != '0;
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: in-flight write tracking, load-use stall, branch flush and forwarding selects
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int WB_DEPTH = 3,
    parameter int FLUSH_SLOTS = 2,
    parameter int CNT_W = 2
) (
    input logic clk,
    input logic reset,
    hazard_scoreboard_if.slave bus
);
    localparam int FC_W = $clog2(FLUSH_SLOTS + 1);
    stage_t s [1:WB_DEPTH];
    logic [FC_W-1:0] flush_cnt;
    logic flush_active;
    logic load_use;
    logic issue;
    assign flush_active = !reset && (bus.ex_branch_taken || flush_cnt != '0);
    assign load_use = s[1].v && s[1].ld && (s[1].rd == bus.id_rs || (bus.id_uses_rt && s[1].rd == bus.id_rt));
    assign bus.stall = bus.id_valid && load_use && !flush_active;
    assign bus.id_ex_bubble = bus.stall || flush_active;
    assign bus.if_id_flush = flush_active;
    // r0 is filtered here, so it never enters the pipe and never matches a source
    assign issue = bus.id_valid && bus.id_reg_write && bus.id_rd != '0 && !bus.stall && !flush_active;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 1; k <= WB_DEPTH; k++) s[k] <= '0;
            flush_cnt <= '0;
            bus.fwd_a <= FWD_REGFILE;
            bus.fwd_b <= FWD_REGFILE;
        end else begin
            s[1] <= '{v: issue, rd: bus.id_rd, ld: bus.id_mem_read};
            for (int k = 1; k < WB_DEPTH; k++) s[k+1] <= s[k];
            flush_cnt <= bus.ex_branch_taken ? FC_W'(FLUSH_SLOTS) : (flush_cnt != '0) ? flush_cnt - 1'b1 : flush_cnt;
            bus.fwd_a <= bus.id_ex_bubble ? FWD_REGFILE : fwd_sel(s[1], s[2], bus.id_rs);
            bus.fwd_b <= bus.id_ex_bubble ? FWD_REGFILE : fwd_sel(s[1], s[2], bus.id_rt);
        end
    end
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        reg_pending_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk(clk),
            .reset(reset),
            .inc(issue && bus.id_rd == REG_ADDR_W'(g)),
            .dec(s[WB_DEPTH].v && s[WB_DEPTH].rd == REG_ADDR_W'(g)),
            .busy(bus.busy[g])
        );
    end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Parametrised hazard and forwarding controller for the 5-stage pipeline (IF, ID, EX, DM, WB).
- Tracks every in-flight register write from ID issue to WB retire in a shift pipeline plus per-register pending counters.
- Produces stall, bubble, flush and forwarding-select controls consumed by the pipeline registers and the EX operand muxes.
- Replaces the unused per-register busy flags with a real scoreboard, load-use detection and branch flush sequencing.

Parameters:
REG_ADDR_W, 5, register address width
NUM_REGS, 32, architectural registers (2**REG_ADDR_W)
WB_DEPTH, 3, stages from EX entry to WB retire (EX, DM, WB)
FLUSH_SLOTS, 2, cycles of ID/IF kill after a taken branch
CNT_W, 2, pending-counter width (must hold WB_DEPTH)

Ports:
clk  in  1  pipeline clock
reset  in  1  asynchronous, active-high reset
id_valid  in  1  ID holds a real instruction
id_rs  in  REG_ADDR_W  source A address
id_rt  in  REG_ADDR_W  source B address
id_uses_rt  in  1  instruction reads rt as an operand (not immediate-only)
id_rd  in  REG_ADDR_W  destination after the reg_dst mux
id_reg_write  in  1  ID instruction writes the register file
id_mem_read  in  1  ID instruction is a load
ex_branch_taken  in  1  branch resolved taken in EX (1-cycle pulse)
stall  out  1  hold PC and IF_ID; load-use detected
id_ex_bubble  out  1  zero control bits entering ID_EX next edge
if_id_flush  out  1  kill the IF_ID contents
fwd_a  out  2  EX operand A source: 0 regfile, 1 EX_DM alu, 2 DM_WB result
fwd_b  out  2  same for operand B
busy  out  NUM_REGS  bit r = pending write to register r

Behaviour:
- Stage pipe s[1..WB_DEPTH], each entry {v, rd, ld}. s[1] = instruction in EX.
- On each edge, s[k+1] <= s[k].
- s[1] <= {id_valid & id_reg_write & (id_rd!=0) & ~stall & ~flush_active, id_rd, id_mem_read}.
- Register 0 is never tracked, never forwarded, and never causes a stall.
- Pending counters cnt[r]:
  - +1 when an entry enters s[1]; -1 when s[WB_DEPTH] retires (v=1).
  - Increment and decrement of the same r in the same cycle leave cnt unchanged.
  - busy[r] = (cnt[r] != 0).
  - Saturation never occurs. A bench assertion flags cnt > WB_DEPTH.
- Load-use (combinational):
  - stall = id_valid & s[1].v & s[1].ld & (s[1].rd==id_rs | (id_uses_rt & s[1].rd==id_rt)) & ~flush_active.
  - id_ex_bubble = stall | flush_active.
- Forwarding selects are registered so they arrive with the instruction in EX.
  - On an edge where ID advances (no stall): fwd_a <= 1 if s[1].v & s[1].rd==id_rs; else 2 if s[2].v & s[2].rd==id_rs; else 0.
  - The youngest producer has priority. fwd_b is the same using id_rt.
  - On bubble, fwd_a and fwd_b are set to 0.
- WB-to-ID same-cycle read relies on the write-first register file; no select is needed.
- Branch flush:
  - ex_branch_taken loads flush_cnt <= FLUSH_SLOTS.
  - flush_active = (flush_cnt != 0) | ex_branch_taken. flush_cnt decrements to 0 while flush_active.
  - if_id_flush = flush_active.
  - The EX instruction itself is not killed.
- Simultaneous events:
  - Branch taken together with load-use: the flush wins and stall is forced to 0.
  - A new taken branch during an active flush reloads flush_cnt.
- Reset (asynchronous):
  - All s[k].v, cnt, and flush_cnt are cleared; fwd_a and fwd_b are 0.
  - stall, bubble, if_id_flush and busy are all 0 while reset is asserted and on the first edge after release.
  - Reset mid-operation discards all in-flight entries.
- Latency: stall and flush are combinational within the same cycle; forwarding selects have 1-cycle registered latency.

Decomposition:
- Shared package hazard_pkg:
  - FWD_REGFILE=0, FWD_EXDM=1, FWD_DMWB=2;
  - the stage-entry struct {v, rd, ld};
  - REG_ADDR_W/NUM_REGS defaults.
- One natural sub-module: reg_pending_counter, a per-register up/down counter with busy output, instantiated NUM_REGS times by generate.

Test Plan:
- R-type back-to-back (add r3; sub r4 uses r3): second instruction gets fwd_a=1 in EX; no stall; busy[3]=1 for exactly 3 cycles.
- Distance-2 dependency (add r5; nop; or r6 uses r5 as rt): fwd_b=2; producer two stages ahead; no stall.
- Load-use (lw r7; add r8 uses r7): stall=1 and id_ex_bubble=1 for exactly one cycle, then fwd_a=2; cnt[7] peaks at 1.
- ex_branch_taken pulse with FLUSH_SLOTS=2: if_id_flush=1 for 3 consecutive cycles (pulse + 2); no entries issued during them; busy remains only for older instructions.
- Load-use coincident with ex_branch_taken: stall=0, flush=1; the lw entry still retires normally.
- Writes to r0 and async reset asserted mid-stream with 3 entries in flight: busy[0] never set; after reset, busy=0, all outputs 0 immediately, and the counters are consistent on the next issue.
